// File: rtl/fifo_ctrl_non2n.sv
// fifo_ctrl_non2n: single-clock FIFO controller for any DEPTH. It holds the pointers and occupancy and drives the RAM enables and addresses.
// Define FIFO_ALMOST_EN to build the almost_full/almost_empty flags.
module fifo_ctrl_non2n #(
    parameter int PTR_WIDTH = 10,
    parameter int DEPTH     = 1000,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic                 rd_req,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 mem_w_en,
    output logic [PTR_WIDTH-1:0] mem_waddr,
    output logic                 mem_r_en,
    output logic [PTR_WIDTH-1:0] mem_raddr,
`ifdef FIFO_ALMOST_EN
    output logic                 rd_valid,
    output logic                 almost_full,
    output logic                 almost_empty
`else
    output logic                 rd_valid
`endif
);

    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = (PTR_WIDTH)'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = (PTR_WIDTH)'(1);
    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH + 1)'(1);

    // Elaboration-time sanity check of the configuration.
    if (DEPTH < 2 || DEPTH > (1 << PTR_WIDTH) || AF_THRESH > DEPTH || AE_THRESH < 0) begin : g_bad_params
        $error("fifo_ctrl_non2n: illegal DEPTH/PTR_WIDTH/threshold combination");
    end

    logic [PTR_WIDTH-1:0] wptr_reg, wptr_next;
    logic [PTR_WIDTH-1:0] rptr_reg, rptr_next;
    logic [PTR_WIDTH:0]   count_reg, count_next;
    logic                 rd_valid_reg;
    logic                 full_int;
    logic                 empty_int;
    logic                 wr_ok;
    logic                 rd_ok;

    // Flags come only from the registered count, so there is no request-to-flag path.
    assign full_int  = (count_reg == FULL_COUNT);
    assign empty_int = (count_reg == '0);
    assign wr_ok     = wr_req & ~full_int;
    assign rd_ok     = rd_req & ~empty_int;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power of two.
        if (wr_ok) begin
            wptr_next = (wptr_reg == LAST_PTR) ? '0 : wptr_reg + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_next = (rptr_reg == LAST_PTR) ? '0 : rptr_reg + PTR_ONE;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            rd_valid_reg <= rd_ok;
        end
    end

    assign full      = full_int;
    assign empty     = empty_int;
    assign count     = count_reg;
    assign mem_w_en  = wr_ok;
    assign mem_waddr = wptr_reg;
    assign mem_r_en  = rd_ok;
    assign mem_raddr = rptr_reg;
    assign rd_valid  = rd_valid_reg;

`ifdef FIFO_ALMOST_EN
    localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LEVEL = (PTR_WIDTH + 1)'(AE_THRESH);

    assign almost_full  = (count_reg >= AF_LEVEL);
    assign almost_empty = (count_reg <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_fifo_ctrl_non2n.sv
// Randomized self-checking bench for fifo_ctrl_non2n (DEPTH=5) against a queue-based occupancy model.
// A small registered-read RAM here stores data so that read order can be checked.
module tb_fifo_ctrl_non2n;
    localparam int PTR_WIDTH = 3;
    localparam int DEPTH     = 5;
    localparam int AF_THRESH = 4;
    localparam int AE_THRESH = 1;

    logic                 clk;
    logic                 rst;
    logic                 wr_req;
    logic                 rd_req;
    logic                 full;
    logic                 empty;
    logic [PTR_WIDTH:0]   count;
    logic                 mem_w_en;
    logic [PTR_WIDTH-1:0] mem_waddr;
    logic                 mem_r_en;
    logic [PTR_WIDTH-1:0] mem_raddr;
    logic                 rd_valid;
`ifdef FIFO_ALMOST_EN
    logic                 almost_full;
    logic                 almost_empty;
`endif

    fifo_ctrl_non2n #(
        .PTR_WIDTH(PTR_WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH),
        .AE_THRESH(AE_THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .mem_w_en    (mem_w_en),
        .mem_waddr   (mem_waddr),
        .mem_r_en    (mem_r_en),
        .mem_raddr   (mem_raddr),
`ifdef FIFO_ALMOST_EN
        .rd_valid    (rd_valid),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`else
        .rd_valid    (rd_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array the controller would drive.
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_waddr] <= wdata;
        if (mem_r_en) rdata <= ram[mem_raddr];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents plus totals of accepted operations since reset.
    logic [15:0] q[$];
    int          wcnt = 0;
    int          rcnt = 0;
    logic [15:0] next_data = 16'h1000;
    logic        m_w_en, m_r_en, m_rdv;
    int          m_waddr, m_raddr;
    logic [15:0] m_rdata;

    // Observed values: pre-edge (enables, addresses) and post-edge (state).
    logic        obs_w_en, obs_r_en;
    int          obs_waddr, obs_raddr;
    int          post_count;
    logic        post_full, post_empty, post_rdv;
    logic [15:0] post_rdata;
    logic        post_af, post_ae;

    task automatic drive(input logic w, input logic r, input logic rs);
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        rst    = rs;
        wdata  = next_data;
        #1;
        m_w_en    = w && (q.size() < DEPTH);
        m_r_en    = r && (q.size() > 0);
        m_waddr   = wcnt % DEPTH;
        m_raddr   = rcnt % DEPTH;
        obs_w_en  = mem_w_en;
        obs_r_en  = mem_r_en;
        obs_waddr = int'(mem_waddr);
        obs_raddr = int'(mem_raddr);
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            wcnt  = 0;
            rcnt  = 0;
            m_rdv = 1'b0;
        end else begin
            if (m_r_en) begin
                m_rdata = q.pop_front();
                rcnt++;
            end
            if (m_w_en) begin
                q.push_back(wdata);
                wcnt++;
                next_data = next_data + 16'd1;
            end
            m_rdv = m_r_en;
        end
        post_count = int'(count);
        post_full  = full;
        post_empty = empty;
        post_rdv   = rd_valid;
        post_rdata = rdata;
`ifdef FIFO_ALMOST_EN
        post_af = almost_full;
        post_ae = almost_empty;
`else
        post_af = 1'b0;
        post_ae = 1'b0;
`endif
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        total++; if (post_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", post_empty); end
        total++; if (post_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", post_full); end
        total++; if (post_count !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", post_count); end
        total++; if (post_rdv !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", post_rdv); end
        total++; if (obs_w_en !== 1'b0 || obs_r_en !== 1'b0) begin
            bad++; $display("FAIL reset_enables got=%b%b want=00", obs_w_en, obs_r_en);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            total++; if (obs_w_en !== 1'b1 || obs_waddr !== i) begin
                bad++; $display("FAIL fill_write i=%0d got w_en=%b addr=%0d want w_en=1 addr=%0d", i, obs_w_en, obs_waddr, i);
            end
        end
        total++; if (post_full !== 1'b1 || post_count !== DEPTH) begin
            bad++; $display("FAIL fill_full got full=%b count=%0d want full=1 count=%0d", post_full, post_count, DEPTH);
        end
        drive(1'b1, 1'b0, 1'b0);
        total++; if (obs_w_en !== 1'b0 || obs_waddr !== 0 || post_count !== DEPTH) begin
            bad++; $display("FAIL fill_overflow got w_en=%b addr=%0d count=%0d want 0/0/%0d", obs_w_en, obs_waddr, post_count, DEPTH);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            total++; if (obs_r_en !== 1'b1 || obs_raddr !== i) begin
                bad++; $display("FAIL drain_read i=%0d got r_en=%b addr=%0d want r_en=1 addr=%0d", i, obs_r_en, obs_raddr, i);
            end
            total++; if (post_rdv !== 1'b1 || post_rdata !== m_rdata) begin
                bad++; $display("FAIL drain_data i=%0d got rdv=%b data=%h want rdv=1 data=%h", i, post_rdv, post_rdata, m_rdata);
            end
        end
        total++; if (post_empty !== 1'b1 || post_count !== 0) begin
            bad++; $display("FAIL drain_empty got empty=%b count=%0d want 1/0", post_empty, post_count);
        end
        drive(1'b0, 1'b1, 1'b0);
        total++; if (obs_r_en !== 1'b0 || post_rdv !== 1'b0) begin
            bad++; $display("FAIL drain_underflow got r_en=%b rdv=%b want 0/0", obs_r_en, post_rdv);
        end
    endtask

    task automatic test_wrap();
        int exp_seq [4];
        exp_seq = '{3, 4, 0, 1};
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            total++; if (obs_w_en !== 1'b1 || obs_waddr !== exp_seq[i]) begin
                bad++; $display("FAIL wrap_waddr i=%0d got=%0d want=%0d", i, obs_waddr, exp_seq[i]);
            end
        end
        total++; if (post_count !== 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", post_count); end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++; if (obs_w_en !== 1'b0 || obs_r_en !== 1'b1 || post_count !== DEPTH - 1) begin
            bad++; $display("FAIL simul_full got w=%b r=%b count=%0d want 0/1/%0d", obs_w_en, obs_r_en, post_count, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++; if (obs_w_en !== 1'b1 || obs_r_en !== 1'b0 || post_count !== 1) begin
            bad++; $display("FAIL simul_empty got w=%b r=%b count=%0d want 1/0/1", obs_w_en, obs_r_en, post_count);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++; if (obs_w_en !== 1'b1 || obs_r_en !== 1'b1 || post_count !== 2) begin
            bad++; $display("FAIL simul_mid got w=%b r=%b count=%0d want 1/1/2", obs_w_en, obs_r_en, post_count);
        end
        total++; if (post_rdv !== 1'b1 || post_rdata !== m_rdata) begin
            bad++; $display("FAIL simul_data got rdv=%b data=%h want 1/%h", post_rdv, post_rdata, m_rdata);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        total++; if (post_count !== 3 || post_rdv !== 1'b1) begin
            bad++; $display("FAIL midrst_setup got count=%0d rdv=%b want 3/1", post_count, post_rdv);
        end
        drive(1'b0, 1'b1, 1'b1);
        total++; if (post_count !== 0 || post_empty !== 1'b1 || post_rdv !== 1'b0) begin
            bad++; $display("FAIL midrst got count=%0d empty=%b rdv=%b want 0/1/0", post_count, post_empty, post_rdv);
        end
        drive(1'b1, 1'b0, 1'b0);
        total++; if (obs_waddr !== 0 || post_count !== 1) begin
            bad++; $display("FAIL midrst_restart got addr=%0d count=%0d want 0/1", obs_waddr, post_count);
        end
    endtask

`ifdef FIFO_ALMOST_EN
    task automatic test_almost();
        drive(1'b0, 1'b0, 1'b1);
        for (int c = 0; c <= DEPTH; c++) begin
            if (c > 0) drive(1'b1, 1'b0, 1'b0);
            total++; if (post_af !== (c >= AF_THRESH) || post_ae !== (c <= AE_THRESH)) begin
                bad++; $display("FAIL almost count=%0d got af=%b ae=%b want af=%b ae=%b", c, post_af, post_ae, c >= AF_THRESH, c <= AE_THRESH);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic rs;
        for (int n = 0; n < 400; n++) begin
            rs = ($urandom_range(0, 59) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs);
            total++; if (obs_w_en !== m_w_en || obs_r_en !== m_r_en) begin
                bad++; $display("FAIL rand_en n=%0d got w=%b r=%b want w=%b r=%b", n, obs_w_en, obs_r_en, m_w_en, m_r_en);
            end
            total++; if (obs_waddr !== m_waddr || obs_raddr !== m_raddr) begin
                bad++; $display("FAIL rand_addr n=%0d got wa=%0d ra=%0d want wa=%0d ra=%0d", n, obs_waddr, obs_raddr, m_waddr, m_raddr);
            end
            total++; if (post_count !== q.size() || post_full !== (q.size() == DEPTH) || post_empty !== (q.size() == 0)) begin
                bad++; $display("FAIL rand_count n=%0d got count=%0d full=%b empty=%b want count=%0d", n, post_count, post_full, post_empty, q.size());
            end
            total++; if (post_rdv !== m_rdv || (m_rdv && post_rdata !== m_rdata)) begin
                bad++; $display("FAIL rand_read n=%0d got rdv=%b data=%h want rdv=%b data=%h", n, post_rdv, post_rdata, m_rdv, m_rdata);
            end
`ifdef FIFO_ALMOST_EN
            total++; if (post_af !== (q.size() >= AF_THRESH) || post_ae !== (q.size() <= AE_THRESH)) begin
                bad++; $display("FAIL rand_almost n=%0d got af=%b ae=%b count=%0d", n, post_af, post_ae, q.size());
            end
`endif
        end
    endtask

    initial begin
        rst    = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wdata  = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
`ifdef FIFO_ALMOST_EN
        test_almost();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
